online_v_residual_unit: RTL

- Iteration-level residual unit for the online divider.
- Accumulates one residual word v = residue + q·d contribution as a stream of NUM_CHUNKS signed-digit chunks, LSB chunk first, then forms the MSD upper field.
- Optionally resolves the exact borrow across all buffered chunks and selects the next quotient digit from the top SEL_BITS of the upper field.
- Sits between the residue/q-vector generators and the quotient-digit controller; replaces the per-chunk enable sequencing with an internal FSM and valid/ready handshakes.

---
 rtl/online_v_residual_unit_if.sv | 40 ++++
 rtl/online_v_residual_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/online_v_residual_unit_if.sv
// Handshake bundle for online_v_residual_unit: chunk stream in, v chunk/upper out,
// start/q-digit control handshakes.
interface online_v_residual_unit_if #(
  parameter int W          = 4,
  parameter int UPPER_BITS = 6
);
  logic                  start;
  logic [UPPER_BITS-1:0] res_upper_plus;
  logic [UPPER_BITS-1:0] res_upper_minus;
  logic [1:0]            x_digit;
  logic                  chunk_valid;
  logic                  chunk_ready;
  logic [W-1:0]          q_plus_vec;
  logic [W-1:0]          q_minus_vec;
  logic [W-1:0]          residue_plus;
  logic [W-1:0]          residue_minus;
  logic [W-1:0]          v_plus_vec;
  logic [W-1:0]          v_minus_vec;
  logic                  v_chunk_valid;
  logic [UPPER_BITS-1:0] v_upper_plus;
  logic [UPPER_BITS-1:0] v_upper_minus;
  logic [1:0]            q_value;
  logic                  q_valid;
  logic                  q_ready;
  logic                  busy;

  modport master (
    output start, res_upper_plus, res_upper_minus, x_digit, chunk_valid,
           q_plus_vec, q_minus_vec, residue_plus, residue_minus, q_ready,
    input  chunk_ready, v_plus_vec, v_minus_vec, v_chunk_valid,
           v_upper_plus, v_upper_minus, q_value, q_valid, busy
  );

  modport slave (
    input  start, res_upper_plus, res_upper_minus, x_digit, chunk_valid,
           q_plus_vec, q_minus_vec, residue_plus, residue_minus, q_ready,
    output chunk_ready, v_plus_vec, v_minus_vec, v_chunk_valid,
           v_upper_plus, v_upper_minus, q_value, q_valid, busy
  );
endinterface

// File: rtl/online_v_residual_unit.sv
// Residual word accumulator and quotient-digit selector for the online divider.
// Define V_BORROW_RESOLVE_EN to buffer chunks and resolve the exact borrow before selection.
module online_v_chunk_add #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
endmodule

module online_v_residual_unit #(
  parameter int UNROLLING  = 4,
  parameter int NUM_CHUNKS = 8,
  parameter int UPPER_BITS = 6,
  parameter int SEL_BITS   = 4,
  parameter int CNT_W      = $clog2(NUM_CHUNKS)
) (
  input  logic                      clk,
  input  logic                      async_clear_n,
  online_v_residual_unit_if.slave   bus
);
  localparam int W = UNROLLING;
  // Selection window: S is zero below SEL_LO, all-ones at or above SEL_HI
  localparam logic [UPPER_BITS:0] SEL_LO = (UPPER_BITS+1)'(1) << (UPPER_BITS - SEL_BITS);
  localparam logic [UPPER_BITS:0] SEL_HI = ((UPPER_BITS+1)'(1) << UPPER_BITS) - SEL_LO;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    UPPER,
`ifdef V_BORROW_RESOLVE_EN
    RESOLVE,
`endif
    DONE
  } state_t;

  state_t state, state_nxt;

  // rail 0 = plus vector, rail 1 = minus vector
  logic [1:0][W-1:0]     add_a, add_b, add_sum;
  logic [1:0]            add_cout, cin;
  logic [CNT_W-1:0]      cnt;
  logic [UPPER_BITS-1:0] up_lat_p, up_lat_m, up_nxt_p, up_nxt_m;
  logic [1:0]            x_lat;
  logic                  accept, last_beat, done_entry;
  logic [UPPER_BITS-1:0] sel_p, sel_m, v_full;
  logic                  b_fin;
  logic [1:0]            q_sel;

  assign add_a = {bus.q_minus_vec, bus.q_plus_vec};
  assign add_b = {bus.residue_minus, bus.residue_plus};

  for (genvar g = 0; g < 2; g++) begin : g_rail
    online_v_chunk_add #(.W(W)) u_add (
      .a    (add_a[g]),
      .b    (add_b[g]),
      .cin  (cin[g]),
      .sum  (add_sum[g]),
      .cout (add_cout[g])
    );
  end

  assign bus.chunk_ready = (state == ACCUM);
  assign bus.busy        = (state != IDLE);
  assign accept          = bus.chunk_valid & bus.chunk_ready;
  assign last_beat       = accept && (cnt == CNT_W'(NUM_CHUNKS - 1));
  assign up_nxt_p        = up_lat_p + UPPER_BITS'(cin[0]) + UPPER_BITS'(x_lat[1]);
  assign up_nxt_m        = up_lat_m + UPPER_BITS'(cin[1]) + UPPER_BITS'(x_lat[0]);

`ifdef V_BORROW_RESOLVE_EN
  logic [NUM_CHUNKS-1:0][1:0][W-1:0] chunk_buf;
  logic [NUM_CHUNKS-1:0]             buf_vld;
  logic [1:0][W-1:0]                 rd_data;
  logic [CNT_W:0]                    rd_cnt;
  logic [CNT_W-1:0]                  rd_idx;
  logic                              rd_vld, borrow, borrow_nxt, rd_issue, rd_last;

  assign rd_idx   = rd_cnt[CNT_W-1:0];
  assign rd_issue = rd_cnt < (CNT_W+1)'(NUM_CHUNKS);
  assign rd_last  = rd_cnt == (CNT_W+1)'(NUM_CHUNKS);

  // plus - minus - b < 0  <=>  plus < minus + b
  always_comb begin
    borrow_nxt = borrow;
    if (rd_vld)
      borrow_nxt = {1'b0, rd_data[0]} < ({1'b0, rd_data[1]} + (W+1)'(borrow));
  end

  always_ff @(posedge clk)
    if (accept) chunk_buf[cnt] <= add_sum;

  always_ff @(posedge clk or negedge async_clear_n) begin
    if (!async_clear_n) begin
      buf_vld <= '0;
      rd_data <= '0;
      rd_cnt  <= '0;
      rd_vld  <= 1'b0;
      borrow  <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) buf_vld <= '0;
      else if (accept)                buf_vld[cnt] <= 1'b1;
      if (state == UPPER) begin
        rd_cnt <= '0;
        rd_vld <= 1'b0;
        borrow <= 1'b0;
      end else if (state == RESOLVE) begin
        rd_cnt <= rd_cnt + (CNT_W+1)'(1);
        borrow <= borrow_nxt;
        rd_vld <= rd_issue && buf_vld[rd_idx];
        if (rd_issue) rd_data <= chunk_buf[rd_idx];
      end
    end
  end

  assign sel_p = bus.v_upper_plus;
  assign sel_m = bus.v_upper_minus;
  assign b_fin = borrow_nxt;
`else
  // Truncated estimate: select straight from the upper sums as they are formed
  assign sel_p = up_nxt_p;
  assign sel_m = up_nxt_m;
  assign b_fin = 1'b0;
`endif

  always_comb begin
    q_sel  = 2'b00;
    v_full = sel_p - sel_m - UPPER_BITS'(b_fin);
    if ({1'b0, v_full} >= SEL_LO && {1'b0, v_full} < SEL_HI)
      q_sel = v_full[UPPER_BITS-1] ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge async_clear_n)
    if (!async_clear_n) state <= IDLE;
    else                state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start) state_nxt = ACCUM;
      ACCUM: if (last_beat) state_nxt = UPPER;
`ifdef V_BORROW_RESOLVE_EN
      UPPER:   state_nxt = RESOLVE;
      RESOLVE: if (rd_last) state_nxt = DONE;
`else
      UPPER:   state_nxt = DONE;
`endif
      DONE:  if (bus.q_valid && bus.q_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign done_entry = (state != DONE) && (state_nxt == DONE);

  always_ff @(posedge clk or negedge async_clear_n) begin
    if (!async_clear_n) begin
      cin               <= '0;
      cnt               <= '0;
      up_lat_p          <= '0;
      up_lat_m          <= '0;
      x_lat             <= '0;
      bus.v_plus_vec    <= '0;
      bus.v_minus_vec   <= '0;
      bus.v_chunk_valid <= 1'b0;
      bus.v_upper_plus  <= '0;
      bus.v_upper_minus <= '0;
      bus.q_value       <= '0;
      bus.q_valid       <= 1'b0;
    end else begin
      bus.v_chunk_valid <= accept;
      if (state == IDLE && bus.start) begin
        cin      <= '0;
        cnt      <= '0;
        up_lat_p <= bus.res_upper_plus;
        up_lat_m <= bus.res_upper_minus;
        x_lat    <= bus.x_digit;
      end
      if (accept) begin
        bus.v_plus_vec  <= add_sum[0];
        bus.v_minus_vec <= add_sum[1];
        cin             <= add_cout;
        cnt             <= cnt + CNT_W'(1);
      end
      if (state == UPPER) begin
        bus.v_upper_plus  <= up_nxt_p;
        bus.v_upper_minus <= up_nxt_m;
      end
      if (done_entry) begin
        bus.q_value <= q_sel;
        bus.q_valid <= 1'b1;
      end else if (state == DONE && bus.q_valid && bus.q_ready) begin
        bus.q_valid <= 1'b0;
      end
    end
  end
endmodule
